conv_layer_ctrl: RTL and testbench
==================================

# conv_layer_ctrl

Sequencer for one convolution layer. It scans every output position of every output channel and issues window requests to the conv/ReLU datapath. It collects the 22-bit ReLU results and writes them in raster order into the layer output buffer, with credit-based limiting of in-flight windows. It sits between the layer-level scheduler (start/done) and the conv engine, ReLU stage and output buffer.

## Interface
Parameters:
- IMG_W, 28, input feature-map width
- IMG_H, 28, input feature-map height
- K, 3, kernel size; OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1
- OUT_CH, 6, output channels
- MAX_INFLIGHT, 4, max windows issued but not yet returned (>=1)
- ADDR_W, 12, output buffer address width; must hold OUT_CH*OUT_W*OUT_H-1

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to run the layer
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse on layer completion
- err  out  1  sticky: relu_valid received while nothing in flight; cleared by accepted start
- eng_ready  in  1  conv engine can accept a window this cycle
- win_valid  out  1  window request strobe
- win_col  out  $clog2(OUT_W)  window top-left column
- win_row  out  $clog2(OUT_H)  window top-left row
- win_ch  out  $clog2(OUT_CH)  output channel (kernel select)
- relu_valid  in  1  result strobe from ReLU stage
- relu_data  in  22 signed  result, already rectified
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  22 signed  write data

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 clears col/row/ch, the write counter, the in-flight counter and err, then moves to ISSUE. start is ignored in every other state.
- ISSUE: an issue fires when eng_ready=1 and inflight<MAX_INFLIGHT.
  - On an issue, assert win_valid with the current col/row/ch.
  - Order: col increments; at OUT_W-1 it wraps to 0 and row increments; at OUT_H-1 row wraps to 0 and ch increments.
  - An issue at (OUT_W-1, OUT_H-1, OUT_CH-1) moves the state to DRAIN.
- Return path, active in all states: each relu_valid with inflight>0 produces one write.
  - wr_data = relu_data; wr_addr = write counter, which then increments.
  - Writes are sequential: address = ch*OUT_W*OUT_H + row*OUT_W + col, by in-order return.
- inflight: +1 on issue, -1 on return, unchanged when both occur in the same cycle. It never exceeds MAX_INFLIGHT and never underflows.
- relu_valid with inflight=0: no write, err<=1.
- DRAIN: when the write that brings the write counter to TOTAL = OUT_CH*OUT_W*OUT_H is registered, move to DONE.
- DONE: done=1 for one cycle, then IDLE.
- The datapath returns results in issue order. The block does no reordering.

## Timing
- All outputs are registered. Reset values: busy=0, done=0, err=0, win_valid=0, win_col/row/ch=0, wr_en=0, wr_addr=0, wr_data=0. State is IDLE.
- start sampled at edge E: ISSUE and busy=1 from E. The first win_valid can be high at E+1 if eng_ready=1 and a credit is free, both sampled at E+1.
- win_valid is high only for the cycle after the edge where the issue condition held. There is no hold or retry; eng_ready is a pre-qualified accept.
- Write latency: relu_valid sampled at edge T gives wr_en/wr_addr/wr_data valid in the cycle after T, i.e. registered one cycle later.
- done is high in the same cycle as the final wr_en. busy=0 in that cycle.
- Back-to-back layer: start in the DONE cycle is ignored. start is accepted from the next IDLE cycle.
- Throughput: with eng_ready=1 and datapath latency L <= MAX_INFLIGHT, one issue per cycle. Otherwise issue stalls whenever inflight=MAX_INFLIGHT.
- rstn asserted mid-operation: all state and outputs return to reset values immediately. Results arriving after reset release count as spurious (err=1).

## Test plan
- Reset: hold rstn=0 with start=1 and relu_valid=1. All outputs stay 0. After release, busy=0 and err=0 until start.
- Full layer, defaults, eng_ready=1, fixed 2-cycle return latency:
  - 4056 win_valid pulses, first (0,0,0), last (25,25,5); (25,0,0) followed by (0,1,0); (25,25,0) followed by (0,0,1).
  - 4056 writes with addresses 0..4055 and wr_data matching relu_data.
  - done exactly once, with the final write.
- Credit limit: return latency 10, MAX_INFLIGHT=4. At most 4 issues occur before the first return. Issue and return in the same cycle keep inflight=4, with no gap in the issue stream.
- Backpressure: eng_ready toggles at random. No win_valid while eng_ready=0. Sequence and count match the full-layer case.
- Spurious result: relu_valid in IDLE gives no wr_en and err=1. The next start clears err.
- Reset mid-layer: rstn pulses after 100 issues. Outputs go to 0 and a new start re-issues from (0,0,0) at address 0.

Source files
------------

// File: rtl/conv_layer_ctrl.sv
// Convolution-layer sequencer: scans (col,row,ch) output positions, issues window
// requests under a credit limit and writes returned ReLU results in raster order.
module conv_layer_ctrl #(
    parameter  int IMG_W        = 28,
    parameter  int IMG_H        = 28,
    parameter  int K            = 3,
    parameter  int OUT_CH       = 6,
    parameter  int MAX_INFLIGHT = 4,
    parameter  int ADDR_W       = 12,
    localparam int OUT_W        = IMG_W - K + 1,
    localparam int OUT_H        = IMG_H - K + 1,
    localparam int COL_W        = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int ROW_W        = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CH_W         = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int DATA_W       = 22
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     eng_ready,
    output logic                     win_valid,
    output logic [COL_W-1:0]         win_col,
    output logic [ROW_W-1:0]         win_row,
    output logic [CH_W-1:0]          win_ch,
    input  logic                     relu_valid,
    input  logic signed [DATA_W-1:0] relu_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data
);

    localparam int TOTAL = OUT_CH * OUT_W * OUT_H;
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(OUT_H - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(OUT_CH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOTAL - 1);
    localparam logic [IF_W-1:0]   IF_MAX    = IF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [CH_W-1:0]    ch;
    logic [ADDR_W-1:0]  wr_cnt;
    logic [IF_W-1:0]    inflight;

    logic issue;
    logic ret;
    logic spurious;
    logic accept;
    logic last_pos;
    logic last_wr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Returns are counted against in-flight credits in every state, so a
    // result with nothing outstanding is flagged instead of written.
    always_comb begin
        issue     = (state == ISSUE) && eng_ready && (inflight < IF_MAX);
        ret       = relu_valid && (inflight != '0);
        spurious  = relu_valid && (inflight == '0);
        accept    = (state == IDLE) && start;
        last_pos  = (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);
        last_wr   = ret && (wr_cnt == ADDR_LAST);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue && last_pos) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (accept) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (issue) begin
            if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                    row <= '0;
                    ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            inflight <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (ret) wr_cnt <= wr_cnt + 1'b1;
            if (spurious) err <= 1'b1;
        end
    end

    // Output register stage: window request and buffer write, one cycle after the decision edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            win_ch    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            busy      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done      <= (state_nxt == DONE);
            win_valid <= issue;
            wr_en     <= ret;
            if (issue) begin
                win_col <= col;
                win_row <= row;
                win_ch  <= ch;
            end
            if (ret) begin
                wr_addr <= wr_cnt;
                wr_data <= relu_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: emulated conv datapath with configurable return
// latency, random backpressure and data, checked against a position-index model.
module tb_conv_layer_ctrl;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int OUT_CH = 6;
    localparam int MAXI   = 4;
    localparam int ADDR_W = 12;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int TOTAL  = OUT_CH * OUT_W * OUT_H;
    localparam int COL_W  = $clog2(OUT_W);
    localparam int ROW_W  = $clog2(OUT_H);
    localparam int CH_W   = $clog2(OUT_CH);
    localparam int LIMIT  = 20000;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic eng_ready = 1'b0;
    logic relu_valid = 1'b0;
    logic signed [21:0] relu_data = '0;

    logic busy, done, err, win_valid, wr_en;
    logic [COL_W-1:0] win_col;
    logic [ROW_W-1:0] win_row;
    logic [CH_W-1:0]  win_ch;
    logic [ADDR_W-1:0] wr_addr;
    logic signed [21:0] wr_data;

    conv_layer_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .OUT_CH(OUT_CH),
        .MAX_INFLIGHT(MAXI), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
        .eng_ready(eng_ready), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .win_ch(win_ch), .relu_valid(relu_valid),
        .relu_data(relu_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state: positions are plain linear indices
    int phase, m_issued, m_written, m_inflight;
    bit m_err;
    bit exp_win, exp_wr, exp_done, exp_busy, exp_zero;
    int exp_col, exp_row, exp_ch, exp_addr;
    logic signed [21:0] exp_data;

    // datapath emulation and bookkeeping
    int cyc = 0;
    int lat = 2;
    bit rnd_ready = 0;
    int pend[$];
    int n_iss, n_wr, n_done, n_ret, iss_at_first_ret, max_out;
    bit seen_ret;
    bit relu_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        phase = P_IDLE;
        m_issued = 0;
        m_written = 0;
        m_inflight = 0;
        m_err = 0;
    endtask

    task automatic model_edge();
        bit iss, ret, spur;
        exp_win = 0;
        exp_wr = 0;
        exp_done = 0;
        exp_zero = 0;
        if (!rstn) begin
            model_reset();
            exp_zero = 1;
        end else begin
            iss  = (phase == P_ISSUE) && eng_ready && (m_inflight < MAXI);
            ret  = relu_valid && (m_inflight > 0);
            spur = relu_valid && (m_inflight == 0);
            if (iss) begin
                exp_win = 1;
                exp_col = m_issued % OUT_W;
                exp_row = (m_issued / OUT_W) % OUT_H;
                exp_ch  = m_issued / (OUT_W * OUT_H);
                m_issued++;
            end
            if (ret) begin
                exp_wr = 1;
                exp_addr = m_written;
                exp_data = relu_data;
                m_written++;
            end
            m_inflight = m_inflight + int'(iss) - int'(ret);
            if (spur) m_err = 1;
            case (phase)
                P_IDLE: if (start) begin
                    phase = P_ISSUE;
                    m_issued = 0;
                    m_written = 0;
                    m_inflight = 0;
                    m_err = 0;
                end
                P_ISSUE: if (m_issued == TOTAL) phase = P_DRAIN;
                P_DRAIN: if (ret && m_written == TOTAL) begin
                    phase = P_DONE;
                    exp_done = 1;
                end
                default: phase = P_IDLE;
            endcase
        end
        exp_busy = (phase == P_ISSUE) || (phase == P_DRAIN);
    endtask

    task automatic check_outputs();
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("err", err, m_err);
        chk("win_valid", win_valid, exp_win);
        chk("wr_en", wr_en, exp_wr);
        if (exp_win) begin
            chk("win_col", win_col, exp_col);
            chk("win_row", win_row, exp_row);
            chk("win_ch", win_ch, exp_ch);
        end
        if (exp_wr) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, exp_data);
        end
        if (exp_zero) begin
            chk("rst_win_col", win_col, 0);
            chk("rst_win_row", win_row, 0);
            chk("rst_win_ch", win_ch, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
        end
    endtask

    task automatic clear_counts();
        n_iss = 0;
        n_wr = 0;
        n_done = 0;
        n_ret = 0;
        iss_at_first_ret = -1;
        max_out = 0;
        seen_ret = 0;
    endtask

    task automatic step();
        model_edge();
        relu_prev = relu_valid;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (relu_prev && rstn) begin
            if (!seen_ret) begin
                seen_ret = 1;
                iss_at_first_ret = n_iss;
            end
            n_ret++;
        end
        if (win_valid) begin
            pend.push_back(cyc + lat);
            n_iss++;
        end
        if (wr_en) n_wr++;
        if (done) n_done++;
        if (n_iss - n_ret > max_out) max_out = n_iss - n_ret;
        eng_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0] <= cyc + 1) begin
            void'(pend.pop_front());
            relu_valid = 1'b1;
            relu_data = 22'($urandom_range(0, 32'h1FFFFF));
        end else begin
            relu_valid = 1'b0;
        end
    endtask

    task automatic run_layer(input int l, input bit rnd, input bit start_in_done);
        int guard;
        lat = l;
        rnd_ready = rnd;
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (n_done == 0 && guard < LIMIT) begin
            step();
            guard++;
        end
        chk("layer_timeout", (guard < LIMIT) ? 32'd1 : 32'd0, 1);
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("layer_issues", n_iss, TOTAL);
        chk("layer_writes", n_wr, TOTAL);
        chk("layer_done_count", n_done, 1);
    endtask

    initial begin
        int guard;
        model_reset();
        clear_counts();

        // reset held with start and relu_valid asserted
        eng_ready = 1'b1;
        repeat (3) begin
            start = 1'b1;
            relu_valid = 1'b1;
            step();
        end
        start = 1'b0;
        relu_valid = 1'b0;
        rstn = 1'b1;
        repeat (3) step();

        // full layer, latency 2, start asserted in the DONE cycle
        run_layer(2, 0, 1);
        chk("idle_after_done_start", busy, 0);

        // spurious result in IDLE, then cleared by the next start
        relu_valid = 1'b1;
        relu_data = 22'sd1234;
        step();
        chk("spurious_err", err, 1);
        step();

        // credit limit with latency 10
        run_layer(10, 0, 0);
        chk("credit_first_ret", iss_at_first_ret, MAXI);
        chk("credit_max_out", max_out, MAXI);

        // random backpressure
        run_layer(2, 1, 0);

        // reset pulse mid-layer
        lat = 2;
        rnd_ready = 0;
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (n_iss < 100 && guard < 1000) begin
            step();
            guard++;
        end
        chk("midrst_reach", (guard < 1000) ? 32'd1 : 32'd0, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_win_col", win_col, 0);
        chk("midrst_win_row", win_row, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        rstn = 1'b1;
        model_reset();
        repeat (12) step();
        chk("midrst_late_err", err, 1);
        pend.delete();

        // fresh layer restarts from (0,0,0) at address 0
        run_layer(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
